// File: rtl/gray_fifo_ctrl_32.sv
// Pointer/flag controller for a 32-entry single-clock ring buffer.
// Exposes RAM strobes and addresses, Gray-coded pointers, occupancy, status and sticky error flags.

module gray_fifo_ctrl_32_param_chk #(
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input logic clk
);
  localparam bit PARAMS_LEGAL = (AF_LEVEL >= 1) && (AF_LEVEL <= 31) &&
                                (AE_LEVEL >= 1) && (AE_LEVEL <= 31);

  // Flags an out-of-range threshold as soon as the clock runs
  param_legal_a: assert property (@(posedge clk) PARAMS_LEGAL)
    else $error("gray_fifo_ctrl_32: AF_LEVEL=%0d AE_LEVEL=%0d outside 1..31", AF_LEVEL, AE_LEVEL);
endmodule

module gray_fifo_ctrl_32 #(
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       flush,
  input  logic       err_clr,
  output logic       wr_en,
  output logic       rd_en,
  output logic [4:0] wr_addr,
  output logic [4:0] rd_addr,
  output logic [5:0] wr_gray,
  output logic [5:0] rd_gray,
  output logic [5:0] level,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       ovf_err,
  output logic       udf_err
);
  localparam logic [5:0] AF_W = 6'(AF_LEVEL);
  localparam logic [5:0] AE_W = 6'(AE_LEVEL);

  function automatic logic [5:0] bin2gray(input logic [5:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [5:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s, level_nxt_s;
  logic [5:0] wr_gray_r, rd_gray_r, level_r;
  logic       full_r, empty_r, almost_full_r, almost_empty_r;
  logic       ovf_err_r, udf_err_r, ovf_nxt_s, udf_nxt_s;
  logic       wr_en_s, rd_en_s, ovf_set_s, udf_set_s;

  gray_fifo_ctrl_32_param_chk #(.AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)) u_param_chk (.clk(clk));

  assign wr_en_s   = wr_req & ~full_r & ~flush;
  assign rd_en_s   = rd_req & ~empty_r & ~flush;
  assign ovf_set_s = wr_req & full_r & ~flush;
  assign udf_set_s = rd_req & empty_r & ~flush;

  // Next pointer values; reset and flush both return the ring to its origin
  always_comb begin
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    if (!reset_n || flush) begin
      wptr_nxt_s = 6'd0;
      rptr_nxt_s = 6'd0;
    end else begin
      wptr_nxt_s = wptr_r + {5'd0, wr_en_s};
      rptr_nxt_s = rptr_r + {5'd0, rd_en_s};
    end
    level_nxt_s = wptr_nxt_s - rptr_nxt_s;
  end

  // Sticky error next state: reset clears, a new event beats err_clr
  always_comb begin
    ovf_nxt_s = ovf_err_r;
    udf_nxt_s = udf_err_r;
    if (!reset_n) begin
      ovf_nxt_s = 1'b0;
      udf_nxt_s = 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_nxt_s = 1'b1;
      end else if (err_clr) begin
        ovf_nxt_s = 1'b0;
      end else begin
        ovf_nxt_s = ovf_err_r;
      end
      if (udf_set_s) begin
        udf_nxt_s = 1'b1;
      end else if (err_clr) begin
        udf_nxt_s = 1'b0;
      end else begin
        udf_nxt_s = udf_err_r;
      end
    end
  end

  // State registers; flags are derived from the next level so they never lag it
  always_ff @(posedge clk) begin
    wptr_r         <= wptr_nxt_s;
    rptr_r         <= rptr_nxt_s;
    wr_gray_r      <= bin2gray(wptr_nxt_s);
    rd_gray_r      <= bin2gray(rptr_nxt_s);
    level_r        <= level_nxt_s;
    full_r         <= (level_nxt_s == 6'd32);
    empty_r        <= (level_nxt_s == 6'd0);
    almost_full_r  <= (level_nxt_s >= AF_W);
    almost_empty_r <= (level_nxt_s <= AE_W);
    ovf_err_r      <= ovf_nxt_s;
    udf_err_r      <= udf_nxt_s;
  end

  assign wr_en        = wr_en_s;
  assign rd_en        = rd_en_s;
  assign wr_addr      = wptr_r[4:0];
  assign rd_addr      = rptr_r[4:0];
  assign wr_gray      = wr_gray_r;
  assign rd_gray      = rd_gray_r;
  assign level        = level_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign ovf_err      = ovf_err_r;
  assign udf_err      = udf_err_r;
endmodule

// File: tb/tb_gray_fifo_ctrl_32.sv
// Scoreboard bench for gray_fifo_ctrl_32: directed scenarios followed by random traffic,
// expectations come from an integer occupancy model.
module tb_gray_fifo_ctrl_32;
  logic clk = 1'b0;
  logic reset_n = 1'b0, wr_req = 1'b0, rd_req = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic wr_en, rd_en, full, empty, almost_full, almost_empty, ovf_err, udf_err;
  logic [4:0] wr_addr, rd_addr;
  logic [5:0] wr_gray, rd_gray, level;

  gray_fifo_ctrl_32 dut (
    .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
    .err_clr(err_clr), .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_gray(wr_gray), .rd_gray(rd_gray), .level(level), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ew, er, wstep, rstep;
    logic [33:0] st;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;
  int wc = 0, rc = 0;
  bit m_ovf = 1'b0, m_udf = 1'b0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; the model works on total accepted write/read counts.
  task automatic step(input bit rn, input bit w, input bit r, input bit f, input bit c);
    exp_t e;
    int lvl;
    bit aw, ar, fm, em;
    logic [5:0] wp, rp, lv;
    @(negedge clk);
    reset_n = rn; wr_req = w; rd_req = r; flush = f; err_clr = c;
    lvl = wc - rc;
    fm = (lvl == 32);
    em = (lvl == 0);
    aw = w && !fm && !f;
    ar = r && !em && !f;
    e.ew = aw; e.er = ar;
    e.wstep = rn && aw; e.rstep = rn && ar;
    if (!rn) begin
      wc = 0; rc = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (f) begin wc = 0; rc = 0; end
      else begin wc += int'(aw); rc += int'(ar); end
      if (w && fm && !f) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && em && !f) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    end
    lvl = wc - rc;
    wp = 6'(wc % 64);
    rp = 6'(rc % 64);
    lv = 6'(lvl);
    e.st = {wp[4:0], rp[4:0], wp ^ (wp >> 1), rp ^ (rp >> 1), lv,
            lvl == 32, lvl == 0, lvl >= 28, lvl <= 4, m_ovf, m_udf};
    exp_q.push_back(e);
  endtask

  // Monitor: strobes checked mid-cycle, registered state checked just after the edge
  initial begin
    logic [5:0] pwg, prg;
    exp_t e;
    pwg = 6'd0; prg = 6'd0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("strobes", {32'd0, wr_en, rd_en}, {32'd0, e.ew, e.er});
        @(posedge clk);
        #1;
        check("state", {wr_addr, rd_addr, wr_gray, rd_gray, level, full, empty,
                        almost_full, almost_empty, ovf_err, udf_err}, e.st);
        if (e.wstep) check("wr_gray_onebit", 34'($countones(pwg ^ wr_gray)), 34'd1);
        if (e.rstep) check("rd_gray_onebit", 34'($countones(prg ^ rd_gray)), 34'd1);
        pwg = wr_gray; prg = rd_gray;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int pw, pr;
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    // fill, overflow, drain, underflow, clear
    repeat (32) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (32) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    // boundary simultaneity at empty then full
    step(1, 1, 1, 0, 0);
    repeat (31) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    // wrap at level 5
    step(0, 0, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0);
    repeat (100) step(1, 1, 1, 0, 0);
    // flush at level 17 with a pending error
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (17) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    // reset from level 20 with ovf set
    repeat (33) step(1, 1, 0, 0, 0);
    repeat (12) step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    // random traffic in phases biased toward filling or draining
    for (int ph = 0; ph < 40; ph++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 64; i++)
        step($urandom_range(0, 299) != 0, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0);
    end
    step(1, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
